// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package imem_pkg;

  // LOAD: boot image streaming in, core held. RUN: fetch port live.
  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } imem_state_t;

  // ARM "mov r0,r0", handed to decode whenever there is no real instruction.
  localparam logic [31:0] ARM_NOP         = 32'hE1A00000;
  localparam logic [31:0] IMEM_RESET_WORD = 32'hFFFFFFFF;

endpackage

// File: rtl/imem_ram.sv
// Single-write, single-read synchronous RAM. No reset; the array keeps its
// contents across RESET so a reload can overwrite only what it needs.
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                     CLK,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port and registered read port; rd_data holds when rd_en is low.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instruction_memory.sv
// Loadable instruction memory: boot-load stream fills the RAM while the core
// is held, then the fetch port serves one registered instruction per cycle
// with stall hold and fault flagging.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   LOAD  | load_ready=1, cpu_hold=1, each handshake writes word wr_ptr
//   RUN   | fetch active, load port ignored, reload returns to LOAD
module instruction_memory
  import imem_pkg::*;
#(
  parameter int                 DATA_W     = 32,
  parameter int                 ADDR_W     = 32,
  parameter int                 DEPTH      = 64,
  parameter logic [DATA_W-1:0]  NOP_WORD   = DATA_W'(ARM_NOP),
  parameter logic [DATA_W-1:0]  RESET_WORD = {DATA_W{1'b1}}
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     stall,
  output logic [DATA_W-1:0]        instr,
  output logic                     fault,
  input  logic                     load_valid,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     load_last,
  output logic                     load_ready,
  input  logic                     reload,
  output logic                     cpu_hold,
  output logic [$clog2(DEPTH):0]   load_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  imem_state_t        state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   load_count_q, load_count_d;
  logic               use_ram_q, use_ram_d;
  logic               rst_word_q, rst_word_d;
  logic               fault_q, fault_d;

  logic               ram_we;
  logic               ram_re;
  logic [DATA_W-1:0]  ram_rd_data;
  logic [ADDR_W-1:0]  idx;
  logic               misaligned;
  logic               in_range;

  // Full-width index so addresses beyond the array never alias low words.
  assign idx        = address >> 2;
  assign misaligned = |address[1:0];
  assign in_range   = idx < ADDR_W'(load_count_q);

  // Load/run sequencing: write pointer, image length and state transitions.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    load_count_d = load_count_q;
    ram_we       = 1'b0;
    case (state_q)
      LOAD: begin
        if (load_valid) begin
          ram_we = 1'b1;
          if (load_last || (wr_ptr_q == PTR_W'(DEPTH - 1))) begin
            state_d      = RUN;
            load_count_d = CNT_W'(wr_ptr_q) + CNT_W'(1);
            wr_ptr_d     = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end
      RUN: begin
        if (reload) begin
          state_d      = LOAD;
          load_count_d = '0;
          wr_ptr_d     = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Fetch decode: choose RAM data or the NOP filler and flag faults; stall holds all.
  always_comb begin
    use_ram_d  = use_ram_q;
    rst_word_d = rst_word_q;
    fault_d    = fault_q;
    ram_re     = 1'b0;
    if (!stall) begin
      rst_word_d = 1'b0;
      if ((state_q == RUN) && !misaligned && in_range) begin
        ram_re    = 1'b1;
        use_ram_d = 1'b1;
        fault_d   = 1'b0;
      end else begin
        use_ram_d = 1'b0;
        fault_d   = (state_q == RUN);
      end
    end
  end

  // State and output registers; synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= LOAD;
      wr_ptr_q     <= '0;
      load_count_q <= '0;
      use_ram_q    <= 1'b0;
      rst_word_q   <= 1'b1;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      load_count_q <= load_count_d;
      use_ram_q    <= use_ram_d;
      rst_word_q   <= rst_word_d;
      fault_q      <= fault_d;
    end
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .CLK     (CLK),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_q),
    .wr_data (load_data),
    .rd_en   (ram_re),
    .rd_addr (address[PTR_W+1:2]),
    .rd_data (ram_rd_data)
  );

  // The RAM read register and the select flags are both flops, so instr is registered.
  assign instr      = use_ram_q  ? ram_rd_data :
                      rst_word_q ? RESET_WORD  : NOP_WORD;
  assign fault      = fault_q;
  assign load_ready = (state_q == LOAD);
  assign cpu_hold   = (state_q != RUN);
  assign load_count = load_count_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: reset, load/fetch, faults, stall,
// full-depth load, reload and reset during load.
module tb_instruction_memory;

  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 64;
  localparam logic [31:0] NOP    = 32'hE1A00000;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [ADDR_W-1:0] address;
  logic              stall;
  logic [DATA_W-1:0] instr;
  logic              fault;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              reload;
  logic              cpu_hold;
  logic [6:0]        load_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] img [DEPTH];
  logic [31:0] w23 [23];
  logic [31:0] wfull [DEPTH];

  instruction_memory #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .address    (address),
    .stall      (stall),
    .instr      (instr),
    .fault      (fault),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .reload     (reload),
    .cpu_hold   (cpu_hold),
    .load_count (load_count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Streams img[0..n-1]; load_last on index last_idx (-1 = never).
  task automatic load_image(input int n, input int last_idx);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (load_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready beat %0d: got %b want 1", i, load_ready);
      end
      load_valid = 1'b1;
      load_data  = img[i];
      load_last  = (i == last_idx);
      if (i == n - 1) begin
        checks++;
        if (cpu_hold !== 1'b1) begin
          errors++;
          $display("FAIL cpu_hold_before_last: got %b want 1", cpu_hold);
        end
      end
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = '0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp_i,
                       input logic exp_f, input string name);
    address = a;
    tick();
    checks++;
    if (instr !== exp_i || fault !== exp_f) begin
      errors++;
      $display("FAIL %s addr=%0d: got instr=%h fault=%b want instr=%h fault=%b",
               name, a, instr, fault, exp_i, exp_f);
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) tick();
    checks++;
    if (instr !== 32'hFFFFFFFF || fault !== 1'b0 || cpu_hold !== 1'b1 ||
        load_ready !== 1'b1 || load_count !== 7'd0) begin
      errors++;
      $display("FAIL reset: got instr=%h fault=%b hold=%b ready=%b count=%0d want ffffffff 0 1 1 0",
               instr, fault, cpu_hold, load_ready, load_count);
    end
    RESET = 1'b0;
    tick();
    checks++;
    if (instr !== NOP || fault !== 1'b0) begin
      errors++;
      $display("FAIL fetch_in_load: got instr=%h fault=%b want %h 0", instr, fault, NOP);
    end
  endtask

  task automatic test_load_fetch();
    for (int i = 0; i < 23; i++) img[i] = w23[i];
    load_image(23, 22);
    checks++;
    if (cpu_hold !== 1'b0 || load_count !== 7'd23 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL load23_done: got hold=%b count=%0d ready=%b want 0 23 0",
               cpu_hold, load_count, load_ready);
    end
    fetch(0,  32'hE04F000F, 1'b0, "fetch0");
    fetch(4,  32'hE2802005, 1'b0, "fetch4");
    fetch(88, 32'hE5802064, 1'b0, "fetch88");
    fetch(40, w23[10],      1'b0, "fetch40");
  endtask

  task automatic test_faults();
    fetch(2,   NOP, 1'b1, "misaligned");
    fetch(92,  NOP, 1'b1, "idx_eq_count");
    fetch(4 * DEPTH, NOP, 1'b1, "beyond_depth");
    fetch(4,   32'hE2802005, 1'b0, "recover");
  endtask

  task automatic test_stall();
    fetch(4, 32'hE2802005, 1'b0, "stall_pre");
    stall   = 1'b1;
    address = 8;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr !== 32'hE2802005 || fault !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc %0d: got instr=%h fault=%b want e2802005 0", i, instr, fault);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (instr !== w23[2]) begin
      errors++;
      $display("FAIL stall_release: got %h want %h", instr, w23[2]);
    end
    // A fault held under stall also stays put.
    fetch(2, NOP, 1'b1, "fault_pre");
    stall   = 1'b1;
    address = 0;
    tick();
    checks++;
    if (fault !== 1'b1 || instr !== NOP) begin
      errors++;
      $display("FAIL stall_fault_hold: got instr=%h fault=%b want %h 1", instr, fault, NOP);
    end
    stall = 1'b0;
  endtask

  task automatic test_full_depth();
    pulse_reload();
    for (int i = 0; i < DEPTH; i++) img[i] = wfull[i];
    load_image(DEPTH, -1);
    checks++;
    if (cpu_hold !== 1'b0 || load_count !== 7'd64) begin
      errors++;
      $display("FAIL full_done: got hold=%b count=%0d want 0 64", cpu_hold, load_count);
    end
    fetch(252, wfull[63], 1'b0, "fetch252");
    fetch(0,   wfull[0],  1'b0, "fetch0_full");
    fetch(256, NOP,       1'b1, "wrap_256");
    // Load port ignored in RUN.
    load_valid = 1'b1;
    load_data  = 32'hDEADBEEF;
    fetch(0, wfull[0], 1'b0, "ignore_load_run");
    load_valid = 1'b0;
    checks++;
    if (load_count !== 7'd64 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL run_ignores_load: got count=%0d hold=%b want 64 0", load_count, cpu_hold);
    end
  endtask

  task automatic test_reload_reset();
    address = 0;
    pulse_reload();
    checks++;
    if (cpu_hold !== 1'b1 || load_ready !== 1'b1 || load_count !== 7'd0) begin
      errors++;
      $display("FAIL reload: got hold=%b ready=%b count=%0d want 1 1 0", cpu_hold, load_ready, load_count);
    end
    fetch(0, NOP, 1'b0, "nop_in_load");
    fetch(4, NOP, 1'b0, "nop_in_load2");
    for (int i = 0; i < 5; i++) img[i] = 32'h5500_0000 + i;
    load_image(5, -1);
    checks++;
    if (cpu_hold !== 1'b1 || load_count !== 7'd0) begin
      errors++;
      $display("FAIL mid_load: got hold=%b count=%0d want 1 0", cpu_hold, load_count);
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    checks++;
    if (load_count !== 7'd0 || cpu_hold !== 1'b1 || instr !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL reset_mid_load: got count=%0d hold=%b instr=%h want 0 1 ffffffff",
               load_count, cpu_hold, instr);
    end
    img[0] = 32'h1111_0000;
    img[1] = 32'h2222_0001;
    load_image(2, 1);
    checks++;
    if (load_count !== 7'd2 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL reload2_done: got count=%0d hold=%b want 2 0", load_count, cpu_hold);
    end
    fetch(8, NOP,          1'b1, "reload_addr8");
    fetch(4, 32'h22220001, 1'b0, "reload_addr4");
    fetch(0, 32'h11110000, 1'b0, "reload_addr0");
  endtask

  initial begin
    for (int i = 0; i < 23; i++) w23[i] = 32'hE3A01000 + i;
    w23[0]  = 32'hE04F000F;
    w23[1]  = 32'hE2802005;
    w23[22] = 32'hE5802064;
    for (int i = 0; i < DEPTH; i++) wfull[i] = 32'hA000_0000 + i;

    RESET      = 1'b1;
    address    = '0;
    stall      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    reload     = 1'b0;
    #1;

    test_reset();
    test_load_fetch();
    test_faults();
    test_stall();
    test_full_depth();
    test_reload_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_memory.md
# instruction_memory

Parametrised, loadable instruction memory for the pipelined CPU, replacing the fixed-contents instruction ROM. A boot-load port fills the memory sequentially over a valid/ready stream while the core is held. The fetch port then serves one registered instruction per cycle. The fetch port adds stall hold and fault flagging for misaligned or unloaded addresses. It sits between the fetch stage (PC) and the decode pipeline register.

## Interface
- DATA_W, 32, instruction width in bits
- ADDR_W, 32, byte-address width of the fetch port
- DEPTH, 64, number of instruction words (power of two, ≥2)
- NOP_WORD, 32'hE1A00000, word returned on a fault or during load (ARM `mov r0,r0`)
- RESET_WORD, all ones, value of `instr` while RESET is high

Ports:
- CLK  in  1  clock; all logic on the rising edge
- RESET  in  1  synchronous, active-high
- address  in  ADDR_W  fetch byte address (PC)
- stall  in  1  hold `instr`/`fault` at their current values
- instr  out  DATA_W  registered instruction
- fault  out  1  registered; the word at `instr` is NOP_WORD because of misalignment or an out-of-range address
- load_valid  in  1  load word present
- load_data  in  DATA_W  load word
- load_last  in  1  final word of the image; qualified by `load_valid`
- load_ready  out  1  memory accepts a load word this cycle
- reload  in  1  single-cycle request to re-enter load from RUN
- cpu_hold  out  1  high whenever the state is not RUN; the core must freeze the PC
- load_count  out  $clog2(DEPTH)+1  number of valid words in the current image

## Operation
- States:
  - LOAD: `load_ready` is 1. Each handshake (`load_valid & load_ready`) writes `load_data` to word `wr_ptr`, then increments `wr_ptr`.
  - LOAD exits to RUN on a handshake with `load_last` = 1, or on the handshake writing word DEPTH−1.
  - On exit, `load_count` ← `wr_ptr` + 1 and `wr_ptr` ← 0.
  - RUN: `load_ready` is 0, and `load_valid` is ignored.
  - `reload` = 1 in RUN moves to LOAD and clears `load_count` and `wr_ptr`. `reload` in LOAD is ignored.
- After reset the state is LOAD, `wr_ptr` = 0 and `load_count` = 0. Memory array contents are not cleared by reset.
- Fetch, evaluated each cycle in which `stall` = 0 and RESET = 0:
  - idx = address >> 2.
  - In LOAD: `instr` ← NOP_WORD, `fault` ← 0.
  - In RUN, if `address[1:0]` ≠ 0 or idx ≥ `load_count`: `instr` ← NOP_WORD, `fault` ← 1.
  - Otherwise in RUN: `instr` ← mem[idx], `fault` ← 0.
- idx uses full ADDR_W width; there is no wrap-around. For example, address 4·DEPTH is out of range, not an alias of word 0.
- `stall` = 1 holds `instr` and `fault`. `stall` does not affect the load port.
- `cpu_hold` = (state ≠ RUN), decoded combinationally from the state register.

## Timing
- Reset values:
  - `instr` = RESET_WORD, `fault` = 0.
  - `load_ready` = 1 and `cpu_hold` = 1 (state LOAD), `load_count` = 0.
- Fetch latency is 1 cycle: the address presented at edge N appears on `instr` after edge N+1.
- Load throughput is one word per cycle; `load_ready` is never deasserted mid-load.
- Transition at the last handshake, taken at edge N:
  - From N+1: state is RUN, `cpu_hold` = 0, and `load_count` is valid.
  - The first valid fetch is sampled at edge N+1.
- A word written at edge N is readable by a fetch sampled at edge N+1 or later. Write and read never collide, because fetch reads the array only in RUN.
- `reload` at edge N: state is LOAD from N+1, and a fetch sampled at N+1 returns NOP_WORD.
- RESET mid-load: the partial image is discarded (`load_count` = 0) and loading restarts at word 0.

## Structure
- `imem_pkg` holds the state enum `imem_state_t` {LOAD, RUN} and the constants `ARM_NOP` = 32'hE1A00000 and `IMEM_RESET_WORD`.
- Sub-module `imem_ram`: single-write, single-read synchronous RAM with DATA_W×DEPTH, no reset, read-enable input. The top level contains the FSM, pointer, count, fault logic and output registers.

## Test plan
- Reset:
  - Hold RESET for 3 cycles → `instr` = 32'hFFFFFFFF, `fault` = 0, `cpu_hold` = 1, `load_ready` = 1, `load_count` = 0.
- Load and fetch:
  - Load 23 words (E04F000F, E2802005, …, E5802064), with `load_last` on word 22 → `load_count` = 23 and `cpu_hold` falls one cycle later.
  - Fetch addresses 0, 4, 88 → E04F000F, E2802005, E5802064, each 1 cycle after the address.
- Faults:
  - Address 2 → NOP_WORD, `fault` = 1.
  - Address 92 (idx 23 = count) → NOP_WORD, `fault` = 1.
  - Address 4·DEPTH → `fault` = 1.
- Full depth:
  - Stream 64 words with `load_last` never asserted → RUN after word 63, `load_count` = 64.
  - Address 252 returns word 63.
- Stall:
  - Fetch address 4, then assert `stall` for 3 cycles while the address changes to 8 → `instr` stays E2802005.
  - Release `stall` → next cycle `instr` = word 2.
- Reload and reset mid-load:
  - In RUN, pulse `reload` → `cpu_hold` = 1 and fetches return NOP_WORD with `fault` = 0.
  - Load 5 words, assert RESET → `load_count` = 0.
  - Reload 2 words → address 8 faults, address 4 returns the new word 1.
